sram_arbiter_ctrl: RTL
======================

// Module: sram_arbiter_ctrl
// PURPOSE
//  Shares the single 16-bit external SRAM between the CPU data port (32-bit word accesses) and the VGA framebuffer reader (16-bit reads).
//  Splits each CPU word into two half-word SRAM cycles (low half first) and sequences the SRAM pins with fixed setup/active timing.
//  Sits in the SoC between the core/VGA blocks and the SRAM_* top-level pins.
// PARAMETERS
//  ACCESS_CYC   2   active cycles per SRAM half-word access (legal: >=2)
//  STARVE_LIMIT 4   consecutive VGA grants, with CPU waiting, before the CPU is forced in (guard build only)
// PORTS
//  ACLK       in    1   system clock; single clock domain
//  ARESETN    in    1   asynchronous, active-low reset
//  cpu_req    in    1   CPU request; held high until cpu_ack
//  cpu_we     in    1   1=write, 0=read
//  cpu_addr   in    19  word address; SRAM_ADDR = {cpu_addr, half}
//  cpu_wdata  in    32  write data; [15:0] low half, [31:16] high half
//  cpu_be     in    4   byte enables (writes only)
//  cpu_rdata  out   32  read data; valid while cpu_ack high
//  cpu_ack    out   1   one-cycle completion pulse
//  vga_req    in    1   VGA read request; held high until vga_ack
//  vga_addr   in    20  half-word address
//  vga_rdata  out   16  read data; valid while vga_ack high
//  vga_ack    out   1   one-cycle completion pulse
//  SRAM_ADDR  out   20  SRAM address
//  SRAM_DQ    inout 16  SRAM data; high-Z unless this block is writing
//  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  active-low SRAM controls
// BEHAVIOUR
//  - States: IDLE -> SETUP -> ACTIVE (ACCESS_CYC cycles) -> [SETUP of CPU high half] -> DONE -> IDLE.
//  - Arbitration is evaluated only in IDLE. VGA has fixed priority over the CPU.
//  - A granted CPU word is atomic: VGA cannot interleave between its two halves.
//  - Request fields are sampled at grant and must stay stable while req is high.
//  - Requester handshake: the requester may drop req, or present a new request, in the cycle after ack.
//  - DONE: the ack of the granted requester is high for exactly one cycle. The state machine then always returns to IDLE.
//  - CPU write half with both byte enables 0: that half is skipped (no SETUP/ACTIVE).
//    If both halves are skipped, the block goes IDLE -> DONE and acks.
//  - SETUP cycle:
//    - SRAM_ADDR valid; CE_N=0.
//    - Read: OE_N=0.
//    - Write: DQ driven, WE_N=1.
//  - ACTIVE cycles:
//    - CE_N=0; address held.
//    - Read: OE_N=0. SRAM_DQ is sampled on the last ACTIVE edge.
//    - Write: WE_N=0 in ACTIVE cycles 0..ACCESS_CYC-2, WE_N=1 in the last cycle; DQ driven until the end of the last cycle (address/data hold).
//  - LB_N/UB_N: 0 for reads; ~be[2h] / ~be[2h+1] for write half h.
//  - All SRAM and ack outputs are registered.
//  - Latency at ACCESS_CYC=2 (req high in IDLE -> ack):
//    - VGA read: 5 cycles.
//    - CPU read or full write: 8 cycles.
//  - Reset (async; also mid-access):
//    - State to IDLE.
//    - CE_N/OE_N/WE_N/LB_N/UB_N=1; SRAM_ADDR=0; DQ high-Z.
//    - Acks=0; cpu_rdata=0; vga_rdata=0; starvation counter=0.
//    - An interrupted access is dropped and never acked.
//  - Simultaneous vga_req and cpu_req in IDLE: VGA wins, except where the guard build forces the CPU in.
// CONFIGURATION
//  SRAM_ARB_STARVE_GUARD_EN defined:
//   - A 3-bit counter increments on each VGA grant made while cpu_req is high.
//   - It clears on every CPU grant and whenever cpu_req is low in IDLE.
//   - At STARVE_LIMIT the next IDLE arbitration grants the CPU even if vga_req is high.
//  Not defined: strict VGA priority; the counter is not present.
// STRUCTURE
//  Package sram_arb_pkg:
//   - typedef enum state_t {IDLE, SETUP, ACTIVE, DONE}
//   - typedef enum grant_t {GNT_NONE, GNT_VGA, GNT_CPU}
//   - SRAM_AW=20, SRAM_DW=16 constants
//  Sub-module sram_access_seq:
//   - Runs one half-word SETUP/ACTIVE sequence, drives the pins, and returns done plus captured data.
//   - The top holds arbitration, half splitting, the guard counter and the acks.
// TESTING
//  1. Reset mid-write: ARESETN low during ACTIVE -> same cycle: WE_N=1, CE_N=1, DQ=Z; no cpu_ack afterwards.
//  2. VGA read: vga_addr=20'h00123, SRAM returns 16'hBEEF -> vga_ack on cycle 5, vga_rdata=16'hBEEF, OE_N low 3 cycles.
//  3. CPU read: cpu_addr=19'h00010, SRAM has 0x00020=16'h5678 and 0x00021=16'h1234 -> cpu_rdata=32'h12345678 on cycle 8.
//  4. CPU write of 32'hCAFEF00D with cpu_be=4'b1100 -> one SRAM write only: addr 0x..1, DQ=16'hCAFE, LB_N=0, UB_N=0; cpu_ack pulses once.
//  5. Conflict: cpu_req and vga_req rise together in IDLE -> VGA served first; CPU halves never split by VGA; each ack exactly 1 cycle.
//  6. Guard build, vga_req held high continuously with cpu_req high -> CPU granted after exactly 4 VGA grants.
//     Non-guard build, same stimulus -> CPU never granted.

Source files
------------

// File: rtl/sram_arbiter_ctrl_pkg.sv
// Shared types and constants for the SRAM arbiter/controller.
package sram_arb_pkg;

    localparam int unsigned SRAM_AW = 20;
    localparam int unsigned SRAM_DW = 16;

    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, DONE} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_CPU} grant_t;

    // A half needs an SRAM cycle unless it is a write with both byte lanes off.
    function automatic logic half_used(input logic we, input logic [1:0] be);
        return !we || (be != 2'b00);
    endfunction

endpackage

// File: rtl/sram_arbiter_ctrl_if.sv
// Requester-side bus of the SRAM arbiter: CPU word port and VGA half-word read port.
interface sram_arbiter_ctrl_if;
    import sram_arb_pkg::*;

    logic                 cpu_req;
    logic                 cpu_we;
    logic [SRAM_AW-2:0]   cpu_addr;
    logic [31:0]          cpu_wdata;
    logic [3:0]           cpu_be;
    logic [31:0]          cpu_rdata;
    logic                 cpu_ack;

    logic                 vga_req;
    logic [SRAM_AW-1:0]   vga_addr;
    logic [SRAM_DW-1:0]   vga_rdata;
    logic                 vga_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_rdata, cpu_ack,
        output vga_req, vga_addr,
        input  vga_rdata, vga_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_rdata, cpu_ack,
        input  vga_req, vga_addr,
        output vga_rdata, vga_ack
    );

endinterface

// File: rtl/sram_arbiter_ctrl_access_seq.sv
// One half-word SRAM access: SETUP cycle then ACCESS_CYC ACTIVE cycles, registered pins.
module sram_access_seq
    import sram_arb_pkg::*;
#(
    parameter int unsigned ACCESS_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               we,
    input  logic [SRAM_AW-1:0] addr,
    input  logic [SRAM_DW-1:0] wdata,
    input  logic [1:0]         lane_n,
    input  logic [SRAM_DW-1:0] dq_in,
    output logic               done,
    output logic [SRAM_DW-1:0] rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] dq_out,
    output logic               dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n
);

    localparam int unsigned CW = $clog2(ACCESS_CYC);
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYC - 1);

    state_t        phase;
    logic [CW-1:0] cnt;
    logic          we_q;

    // done marks the last ACTIVE cycle; the caller samples rdata on that edge.
    assign done  = (phase == ACTIVE) && (cnt == LAST);
    assign rdata = dq_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            sram_addr <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
        end else if (start) begin
            phase     <= SETUP;
            cnt       <= '0;
            we_q      <= we;
            sram_addr <= addr;
            dq_out    <= wdata;
            dq_oe     <= we;
            sram_ce_n <= 1'b0;
            sram_oe_n <= we;
            sram_we_n <= 1'b1;
            sram_lb_n <= we ? lane_n[0] : 1'b0;
            sram_ub_n <= we ? lane_n[1] : 1'b0;
        end else begin
            case (phase)
                SETUP: begin
                    phase     <= ACTIVE;
                    cnt       <= '0;
                    sram_we_n <= !we_q;
                end
                ACTIVE: begin
                    if (cnt == LAST) begin
                        phase     <= IDLE;
                        dq_oe     <= 1'b0;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        // WE_N rises for the final ACTIVE cycle to give data/address hold.
                        sram_we_n <= !(we_q && ((32'(cnt) + 32'd2) < ACCESS_CYC));
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// SRAM arbiter: VGA priority over CPU, CPU words split into two half-word cycles.
// Optional CPU starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter_ctrl
    import sram_arb_pkg::*;
#(
    parameter int unsigned ACCESS_CYC   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    sram_arbiter_ctrl_if.slave bus,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_UB_N
);

    if (ACCESS_CYC < 2 || STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_param_check
        $error("sram_arbiter_ctrl: illegal ACCESS_CYC or STARVE_LIMIT");
    end

    state_t             state;
    grant_t             gnt;
    logic               half;
    logic               we_q;
    logic [SRAM_AW-2:0] addr_q;
    logic [15:0]        wdata_hi_q;
    logic [1:0]         be_hi_q;
    logic [31:0]        cpu_rdata_q;
    logic [15:0]        vga_rdata_q;
    logic               cpu_ack_q;
    logic               vga_ack_q;

    logic               force_cpu;
    logic               vga_win;
    logic               cpu_win;
    logic               seq_start;
    logic               seq_we;
    logic [SRAM_AW-1:0] seq_addr;
    logic [SRAM_DW-1:0] seq_wdata;
    logic [1:0]         seq_lane_n;
    logic               start_half;
    logic               seq_done;
    logic [SRAM_DW-1:0] seq_rdata;
    logic [SRAM_DW-1:0] dq_out;
    logic               dq_oe;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign force_cpu = bus.cpu_req && (32'(starve_cnt) >= STARVE_LIMIT);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (cpu_win || !bus.cpu_req) begin
                starve_cnt <= '0;
            end else if (vga_win && (starve_cnt != 3'd7)) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end
`else
    assign force_cpu = 1'b0;
`endif

    // Arbitration and half selection; the high half is chained straight off the low half's last edge.
    always_comb begin
        vga_win    = 1'b0;
        cpu_win    = 1'b0;
        seq_start  = 1'b0;
        seq_we     = 1'b0;
        seq_addr   = '0;
        seq_wdata  = '0;
        seq_lane_n = '1;
        start_half = 1'b0;
        if (state == IDLE) begin
            vga_win = bus.vga_req && !force_cpu;
            cpu_win = bus.cpu_req && !vga_win;
            if (vga_win) begin
                seq_start = 1'b1;
                seq_addr  = bus.vga_addr;
            end else if (cpu_win) begin
                seq_we = bus.cpu_we;
                if (half_used(bus.cpu_we, bus.cpu_be[1:0])) begin
                    seq_start  = 1'b1;
                    seq_addr   = {bus.cpu_addr, 1'b0};
                    seq_wdata  = bus.cpu_wdata[15:0];
                    seq_lane_n = ~bus.cpu_be[1:0];
                end else if (half_used(bus.cpu_we, bus.cpu_be[3:2])) begin
                    seq_start  = 1'b1;
                    start_half = 1'b1;
                    seq_addr   = {bus.cpu_addr, 1'b1};
                    seq_wdata  = bus.cpu_wdata[31:16];
                    seq_lane_n = ~bus.cpu_be[3:2];
                end
            end
        end else if (state == ACTIVE && seq_done && gnt == GNT_CPU && !half &&
                     half_used(we_q, be_hi_q)) begin
            seq_start  = 1'b1;
            seq_we     = we_q;
            seq_addr   = {addr_q, 1'b1};
            seq_wdata  = wdata_hi_q;
            seq_lane_n = ~be_hi_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= IDLE;
            gnt         <= GNT_NONE;
            half        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_hi_q  <= '0;
            be_hi_q     <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            vga_ack_q   <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            vga_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (vga_win) begin
                        gnt   <= GNT_VGA;
                        state <= SETUP;
                    end else if (cpu_win) begin
                        gnt        <= GNT_CPU;
                        we_q       <= bus.cpu_we;
                        addr_q     <= bus.cpu_addr;
                        wdata_hi_q <= bus.cpu_wdata[31:16];
                        be_hi_q    <= bus.cpu_be[3:2];
                        half       <= start_half;
                        if (seq_start) begin
                            state <= SETUP;
                        end else begin
                            state     <= DONE;
                            cpu_ack_q <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state <= ACTIVE;
                end
                ACTIVE: begin
                    if (seq_done) begin
                        if (gnt == GNT_VGA) begin
                            vga_rdata_q <= seq_rdata;
                            vga_ack_q   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            if (!we_q) begin
                                if (half) cpu_rdata_q[31:16] <= seq_rdata;
                                else      cpu_rdata_q[15:0]  <= seq_rdata;
                            end
                            if (seq_start) begin
                                half  <= 1'b1;
                                state <= SETUP;
                            end else begin
                                cpu_ack_q <= 1'b1;
                                state     <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    gnt   <= GNT_NONE;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sram_access_seq #(
        .ACCESS_CYC (ACCESS_CYC)
    ) u_seq (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .start     (seq_start),
        .we        (seq_we),
        .addr      (seq_addr),
        .wdata     (seq_wdata),
        .lane_n    (seq_lane_n),
        .dq_in     (SRAM_DQ),
        .done      (seq_done),
        .rdata     (seq_rdata),
        .sram_addr (SRAM_ADDR),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .sram_ce_n (SRAM_CE_N),
        .sram_oe_n (SRAM_OE_N),
        .sram_we_n (SRAM_WE_N),
        .sram_lb_n (SRAM_LB_N),
        .sram_ub_n (SRAM_UB_N)
    );

    assign SRAM_DQ       = dq_oe ? dq_out : {SRAM_DW{1'bz}};
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.vga_rdata = vga_rdata_q;
    assign bus.vga_ack   = vga_ack_q;

endmodule
